wavetable_interp_reader: RTL
============================

# wavetable_interp_reader

Parametrised multi-bank wavetable reader for the synthesizer voice path. It accepts one sample request at a time: a fixed-point phase, a one-hot octave and a bank-mix fraction. It reads two adjacent samples from each of two neighbouring band-limited ROM banks, linearly interpolates in phase within each bank, then crossfades between the two banks. It sits between the per-voice phase accumulators and the voice mixer, and drives the external dual-port bank ROMs, which have a 1-cycle registered read.

## Interface
- SAMP_W, 16: signed sample width.
- ADDR_W, 12: table address width; each table holds 2^ADDR_W samples.
- FRAC_W, 8: phase-fraction and mix-fraction width.
- NUM_BANKS, 8: number of ROM banks, one per octave.
- NUM_VOICES, 4: voice-tag range; VID_W = max(1, $clog2(NUM_VOICES)).
- Clk, in, 1: the single clock.
- Reset_n, in, 1: asynchronous, active-low reset.
- req_valid, in, 1: request present.
- req_ready, out, 1: block can accept; high only in IDLE while not in reset.
- req_phase, in, ADDR_W+FRAC_W: upper ADDR_W bits are the address, lower FRAC_W bits are the phase fraction.
- req_octave, in, NUM_BANKS: one-hot bank select.
- req_mix, in, FRAC_W: unsigned crossfade weight toward bank k+1.
- req_voice, in, VID_W: tag carried through to the output.
- rom_addr_a, out, ADDR_W: read address A for all banks.
- rom_addr_b, out, ADDR_W: read address B for all banks.
- rom_rden, out, 1: read enable for all banks.
- rom_q_a, in, NUM_BANKS×SAMP_W: port A data, per bank.
- rom_q_b, in, NUM_BANKS×SAMP_W: port B data, per bank.
- out_valid, out, 1: result present.
- out_ready, in, 1: consumer accepts the result.
- out_sample, out, SAMP_W: signed result.
- out_voice, out, VID_W: tag of the result.
- out_err, out, 1: the request had an invalid octave.
- busy, out, 1: state is not IDLE.

## Operation
- FSM states: IDLE → READ → LERP0 → LERP1 → MIX → OUT → IDLE. There are no other transitions.
- IDLE: req_ready=1. On req_valid&&req_ready, register the phase, mix and voice tag, decode the octave, and go to READ.
- Octave decode: k = index of the lowest set bit.
  - req_octave==0 gives k=0 and sets the err flag.
  - Multiple set bits give the lowest index and are not an error.
- Upper bank: k1 = k+1, except k1 = k when k = NUM_BANKS-1.
- READ:
  - rom_rden=1.
  - rom_addr_a = registered address.
  - rom_addr_b = (address+1) mod 2^ADDR_W.
- LERP0:
  - Capture rom_q_a/rom_q_b of banks k and k1 into holding registers.
  - Compute L0 = lerp(qa[k], qb[k], frac).
- LERP1: compute L1 = lerp(qa[k1], qb[k1], frac) from the holding registers.
- MIX: compute result = lerp(L0, L1, mix) and register it into out_sample, out_voice and out_err.
- OUT: out_valid=1; hold all outputs stable until out_ready. On out_valid&&out_ready, go to IDLE.
- lerp(a,b,f) = a + (((b−a) × f) >>> FRAC_W).
  - b−a is computed at SAMP_W+1 bits, signed.
  - f is zero-extended.
  - The product is SAMP_W+FRAC_W+2 bits, shifted arithmetically, which floors toward −∞.
  - The result always lies within [min(a,b), max(a,b)], so truncating to SAMP_W never overflows.
- mix=0 gives L0 exactly; frac=0 gives qa exactly.
- rom_rden=0 and the ROM addresses hold their last value in every state other than READ.
- A single multiplier may be shared across LERP0, LERP1 and MIX.

## Timing
- Reset (async, with Reset_n low):
  - State = IDLE.
  - req_ready=0 while reset is asserted, 1 from the first cycle after release.
  - busy=0, rom_rden=0, rom_addr_a/b=0.
  - out_valid=0, out_sample=0, out_voice=0, out_err=0.
  - Holding registers are cleared to 0.
- Request accepted at edge T gives: READ in cycle T+1, LERP0 at T+2, LERP1 at T+3, MIX at T+4, and out_valid high from cycle T+5.
- The earliest next accept is the cycle after the output handshake, giving a minimum of 6 cycles per sample.
- Backpressure: out_ready low holds OUT indefinitely with outputs unchanged; req_ready stays 0.
- req_valid is ignored outside IDLE; a request may be held across busy cycles and is accepted on return to IDLE.
- Reset asserted mid-operation (any state) aborts immediately to the reset values. No partial output is produced.

## Test plan
- Interpolation plus crossfade:
  - Stimulus: req_octave=8'h04, phase address 0x100, frac 0x80, mix 0x40. Bank2 qa=1000, qb=2000; bank3 qa=0, qb=400.
  - Required: L0=1500, L1=200, out_sample=1175.
  - Required: out_valid first seen 5 cycles after accept; rom_addr_a=0x100 and rom_addr_b=0x101 during READ.
- Wrap-around:
  - Stimulus: address 0xFFF, frac 0x40, octave 8'h01, mix 0. qa=−32768, qb=32767.
  - Required: rom_addr_b=0x000 and out_sample=−16385.
- Top bank:
  - Stimulus: octave 8'h80, mix 0xFF, frac 0. Bank7 qa=−500.
  - Required: out_sample=−500 (k1=k), out_err=0.
- Invalid octave:
  - Stimulus: req_octave=0 with bank0 qa=123, frac 0, mix 0.
  - Required: out_sample=123, out_err=1.
  - Required: the next valid request returns out_err=0.
- Backpressure and throughput:
  - Stimulus: out_ready low for 10 cycles, with req_valid held high carrying voice 3.
  - Required: outputs are stable and req_ready=0 throughout.
  - Required: after the handshake, the pending request is accepted on the next cycle, and out_voice=3 appears 5 cycles later.
- Reset mid-op:
  - Stimulus: assert Reset_n=0 during LERP1.
  - Required: all outputs go to their reset values asynchronously, no out_valid pulse occurs, and req_ready=1 the cycle after release.

Source files
------------

// File: rtl/wavetable_interp_reader_if.sv
// -----------------------------------------------------------------------------
// wavetable_interp_reader_if
// Groups the request, bank-ROM and result signals of the wavetable reader.
//   slave  : the reader itself (takes requests, drives ROM addresses/results)
//   master : the environment (phase accumulators, bank ROMs, voice mixer)
// Signals:
//   req_*      request handshake carrying phase, one-hot octave, mix, voice tag
//   rom_*      shared read addresses/enable and per-bank read data (1-cycle ROM)
//   out_*      result handshake carrying sample, voice tag, octave-error flag
//   busy       reader is processing a request
// -----------------------------------------------------------------------------
interface wavetable_interp_reader_if #(
  parameter int SAMP_W     = 16,
  parameter int ADDR_W     = 12,
  parameter int FRAC_W     = 8,
  parameter int NUM_BANKS  = 8,
  parameter int NUM_VOICES = 4
);
  localparam int VID_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  logic                          req_valid;
  logic                          req_ready;
  logic [ADDR_W+FRAC_W-1:0]      req_phase;
  logic [NUM_BANKS-1:0]          req_octave;
  logic [FRAC_W-1:0]             req_mix;
  logic [VID_W-1:0]              req_voice;

  logic [ADDR_W-1:0]             rom_addr_a;
  logic [ADDR_W-1:0]             rom_addr_b;
  logic                          rom_rden;
  logic [NUM_BANKS*SAMP_W-1:0]   rom_q_a;
  logic [NUM_BANKS*SAMP_W-1:0]   rom_q_b;

  logic                          out_valid;
  logic                          out_ready;
  logic signed [SAMP_W-1:0]      out_sample;
  logic [VID_W-1:0]              out_voice;
  logic                          out_err;

  logic                          busy;

  modport slave (
    input  req_valid, req_phase, req_octave, req_mix, req_voice,
    input  rom_q_a, rom_q_b, out_ready,
    output req_ready, rom_addr_a, rom_addr_b, rom_rden,
    output out_valid, out_sample, out_voice, out_err, busy
  );

  modport master (
    output req_valid, req_phase, req_octave, req_mix, req_voice,
    output rom_q_a, rom_q_b, out_ready,
    input  req_ready, rom_addr_a, rom_addr_b, rom_rden,
    input  out_valid, out_sample, out_voice, out_err, busy
  );
endinterface

// File: rtl/wavetable_interp_reader.sv
// -----------------------------------------------------------------------------
// wavetable_interp_reader
// Reads two adjacent samples from two neighbouring band-limited ROM banks,
// interpolates linearly in phase inside each bank, then crossfades between the
// banks. One request in flight; minimum 6 cycles per sample.
// Ports:
//   clk_i   single clock
//   rst_ni  asynchronous active-low reset
//   bus     wavetable_interp_reader_if.slave (request, bank ROM, result, busy)
// -----------------------------------------------------------------------------
module wavetable_interp_reader #(
  parameter int SAMP_W     = 16,
  parameter int ADDR_W     = 12,
  parameter int FRAC_W     = 8,
  parameter int NUM_BANKS  = 8,
  parameter int NUM_VOICES = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  wavetable_interp_reader_if.slave      bus
);
  localparam int VID_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int KW    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int PW    = SAMP_W + FRAC_W + 2;
  localparam logic [KW-1:0] LAST_BANK = KW'(NUM_BANKS - 1);

  typedef enum logic [2:0] {
    IDLE, READ, LERP0, LERP1, MIX, OUT
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0]        rom_addr_a_q, rom_addr_b_q;
  logic [FRAC_W-1:0]        frac_q, mix_q;
  logic [VID_W-1:0]         voice_q;
  logic [KW-1:0]            k_q, k1_q;
  logic                     err_q;
  logic signed [SAMP_W-1:0] qa1_q, qb1_q;
  logic signed [SAMP_W-1:0] l0_q, l1_q;
  logic signed [SAMP_W-1:0] out_sample_q;
  logic [VID_W-1:0]         out_voice_q;
  logic                     out_err_q;

  logic                     accept;
  logic [KW-1:0]            oct_k, oct_k1;
  logic                     oct_err;
  logic [ADDR_W-1:0]        req_addr;

  logic signed [SAMP_W-1:0] qa_k, qb_k, qa_k1, qb_k1;
  logic signed [SAMP_W-1:0] lerp_a, lerp_b, lerp_res;
  logic [FRAC_W-1:0]        lerp_f;
  logic signed [SAMP_W:0]   lerp_diff;
  logic signed [PW-1:0]     lerp_prod;

  // Ready is gated by the reset pin so nothing can be accepted while the
  // block is held in reset even though the state already reads IDLE.
  assign bus.req_ready  = (state_q == IDLE) && rst_ni;
  assign bus.busy       = (state_q != IDLE);
  assign bus.rom_rden   = (state_q == READ);
  assign bus.rom_addr_a = rom_addr_a_q;
  assign bus.rom_addr_b = rom_addr_b_q;
  assign bus.out_valid  = (state_q == OUT);
  assign bus.out_sample = out_sample_q;
  assign bus.out_voice  = out_voice_q;
  assign bus.out_err    = out_err_q;

  assign accept   = (state_q == IDLE) && bus.req_valid;
  assign req_addr = bus.req_phase[ADDR_W+FRAC_W-1:FRAC_W];

  // Lowest set octave bit wins; an empty octave falls back to bank 0 and is
  // flagged. The top bank crossfades with itself.
  always_comb begin
    oct_k   = '0;
    oct_err = (bus.req_octave == '0);
    for (int i = NUM_BANKS - 1; i >= 0; i--) begin
      if (bus.req_octave[i]) oct_k = KW'(i);
    end
    oct_k1 = (oct_k == LAST_BANK) ? oct_k : oct_k + KW'(1);
  end

  // Per-bank slices of the ROM read data for the selected pair of banks.
  assign qa_k  = bus.rom_q_a[k_q*SAMP_W +: SAMP_W];
  assign qb_k  = bus.rom_q_b[k_q*SAMP_W +: SAMP_W];
  assign qa_k1 = bus.rom_q_a[k1_q*SAMP_W +: SAMP_W];
  assign qb_k1 = bus.rom_q_b[k1_q*SAMP_W +: SAMP_W];

  // One interpolator shared by the three arithmetic states. In LERP0 the
  // lower bank is taken straight from the ROM outputs; the upper bank is
  // parked in the holding registers for LERP1.
  always_comb begin
    lerp_a = qa_k;
    lerp_b = qb_k;
    lerp_f = frac_q;
    case (state_q)
      LERP1: begin
        lerp_a = qa1_q;
        lerp_b = qb1_q;
      end
      MIX: begin
        lerp_a = l0_q;
        lerp_b = l1_q;
        lerp_f = mix_q;
      end
      default: ;
    endcase
  end

  // a + floor((b-a)*f / 2^FRAC_W); the result stays between a and b, so the
  // final truncation back to SAMP_W cannot overflow.
  assign lerp_diff = {lerp_b[SAMP_W-1], lerp_b} - {lerp_a[SAMP_W-1], lerp_a};
  assign lerp_prod = PW'(lerp_diff) * $signed({{(PW-FRAC_W){1'b0}}, lerp_f});
  assign lerp_res  = SAMP_W'(PW'(lerp_a) + (lerp_prod >>> FRAC_W));

  // Fixed sequence; only IDLE waits for a request and only OUT waits for
  // the consumer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req_valid) state_d = READ;
      READ:    state_d = LERP0;
      LERP0:   state_d = LERP1;
      LERP1:   state_d = MIX;
      MIX:     state_d = OUT;
      OUT:     if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Datapath registers; each one only moves in the state that owns it, so
  // ROM addresses and results hold their values everywhere else.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rom_addr_a_q <= '0;
      rom_addr_b_q <= '0;
      frac_q       <= '0;
      mix_q        <= '0;
      voice_q      <= '0;
      k_q          <= '0;
      k1_q         <= '0;
      err_q        <= 1'b0;
      qa1_q        <= '0;
      qb1_q        <= '0;
      l0_q         <= '0;
      l1_q         <= '0;
      out_sample_q <= '0;
      out_voice_q  <= '0;
      out_err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            rom_addr_a_q <= req_addr;
            rom_addr_b_q <= req_addr + ADDR_W'(1);
            frac_q       <= bus.req_phase[FRAC_W-1:0];
            mix_q        <= bus.req_mix;
            voice_q      <= bus.req_voice;
            k_q          <= oct_k;
            k1_q         <= oct_k1;
            err_q        <= oct_err;
          end
        end
        LERP0: begin
          qa1_q <= qa_k1;
          qb1_q <= qb_k1;
          l0_q  <= lerp_res;
        end
        LERP1: begin
          l1_q <= lerp_res;
        end
        MIX: begin
          out_sample_q <= lerp_res;
          out_voice_q  <= voice_q;
          out_err_q    <= err_q;
        end
        default: ;
      endcase
    end
  end
endmodule
